// File: rtl/wb_dual_master_arbiter_if.sv
// Wishbone bus bundle for the dual-master arbiter: two master ports (m0 instr, m1 data)
// and the shared slave port. 'slave' is the arbiter's view, 'master' the environment's.
interface wb_dual_master_arbiter_if;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_ack, m0_err;

    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_ack, m1_err;

    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_ack;

    modport slave (
        input  m0_cyc, m0_stb, m0_we, m0_sel, m0_addr, m0_wdata,
        output m0_rdata, m0_ack, m0_err,
        input  m1_cyc, m1_stb, m1_we, m1_sel, m1_addr, m1_wdata,
        output m1_rdata, m1_ack, m1_err,
        output s_cyc, s_stb, s_we, s_sel, s_addr, s_wdata,
        input  s_rdata, s_ack
    );

    modport master (
        output m0_cyc, m0_stb, m0_we, m0_sel, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack, m0_err,
        output m1_cyc, m1_stb, m1_we, m1_sel, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack, m1_err,
        input  s_cyc, s_stb, s_we, s_sel, s_addr, s_wdata,
        output s_rdata, s_ack
    );
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Two-master classic Wishbone arbiter (round-robin / fixed priority) with ack watchdog.
// Define ARB_RESP_REG_EN for a registered response path (adds the RESP state).
module wb_dual_master_arbiter #(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_dual_master_arbiter_if.slave bus,
    output logic [1:0]           grant,
    output logic [CNT_WIDTH-1:0] timeout_cnt
);
    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
`ifdef ARB_RESP_REG_EN
        , RESP = 2'd3
`endif
    } state_t;

    state_t          state;
    logic            last1;
    logic [WD_W-1:0] wd_cnt;
    logic            req0, req1, in_gnt, own1, active;
    logic            expire, ack_hit, wd_err, done;

    assign req0    = bus.m0_cyc & bus.m0_stb;
    assign req1    = bus.m1_cyc & bus.m1_stb;
    assign in_gnt  = (state == GNT0) || (state == GNT1);
    assign own1    = (state == GNT1);
    assign active  = in_gnt & (own1 ? req1 : req0);

    assign expire  = (TIMEOUT_CYCLES != 0) && active && (wd_cnt == WD_W'(TIMEOUT_CYCLES));
    assign ack_hit = active & bus.s_ack;
    assign wd_err  = expire & ~bus.s_ack;
    assign done    = ack_hit | wd_err;

    assign grant   = {state == GNT1, state == GNT0};

    // Slave side is gated by the owner's live request so a dropped cyc aborts at once.
    assign bus.s_cyc   = active;
    assign bus.s_stb   = active;
    assign bus.s_we    = in_gnt & (own1 ? bus.m1_we : bus.m0_we);
    assign bus.s_sel   = in_gnt ? (own1 ? bus.m1_sel   : bus.m0_sel)   : '0;
    assign bus.s_addr  = in_gnt ? (own1 ? bus.m1_addr  : bus.m0_addr)  : '0;
    assign bus.s_wdata = in_gnt ? (own1 ? bus.m1_wdata : bus.m0_wdata) : '0;

`ifdef ARB_RESP_REG_EN
    logic        r_ack0, r_err0, r_ack1, r_err1;
    logic [31:0] r_rdata0, r_rdata1;

    assign bus.m0_ack   = r_ack0;
    assign bus.m0_err   = r_err0;
    assign bus.m0_rdata = r_rdata0;
    assign bus.m1_ack   = r_ack1;
    assign bus.m1_err   = r_err1;
    assign bus.m1_rdata = r_rdata1;
`else
    assign bus.m0_ack   = (state == GNT0) & ack_hit;
    assign bus.m0_err   = (state == GNT0) & wd_err;
    assign bus.m0_rdata = (state == GNT0) ? bus.s_rdata : '0;
    assign bus.m1_ack   = own1 & ack_hit;
    assign bus.m1_err   = own1 & wd_err;
    assign bus.m1_rdata = own1 ? bus.s_rdata : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last1       <= 1'b1;
            wd_cnt      <= '0;
            timeout_cnt <= '0;
`ifdef ARB_RESP_REG_EN
            r_ack0   <= 1'b0;
            r_err0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
`endif
        end else begin
`ifdef ARB_RESP_REG_EN
            r_ack0   <= 1'b0;
            r_err0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
`endif
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (req0 && req1) begin
                        if (PRIORITY_MODE == 1) state <= GNT1;
                        else                    state <= last1 ? GNT0 : GNT1;
                    end else if (req0) begin
                        state <= GNT0;
                    end else if (req1) begin
                        state <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (!active) begin
                        state <= IDLE;
                    end else if (done) begin
                        last1 <= own1;
                        if (wd_err && (timeout_cnt != '1))
                            timeout_cnt <= timeout_cnt + 1'b1;
`ifdef ARB_RESP_REG_EN
                        r_ack0   <= ~own1 & ack_hit;
                        r_err0   <= ~own1 & wd_err;
                        r_ack1   <= own1 & ack_hit;
                        r_err1   <= own1 & wd_err;
                        r_rdata0 <= own1 ? '0 : bus.s_rdata;
                        r_rdata1 <= own1 ? bus.s_rdata : '0;
                        state    <= RESP;
`else
                        state <= IDLE;
`endif
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
`ifdef ARB_RESP_REG_EN
                RESP: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Scoreboard bench for wb_dual_master_arbiter: directed transfers push expected responses,
// a negedge monitor pops and compares every ack/err the masters see.
module tb_wb_dual_master_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_dual_master_arbiter_if ifc ();
    wb_dual_master_arbiter_if fif ();
    logic [1:0] grant, f_grant;
    logic [7:0] tcnt, f_tcnt;

    wb_dual_master_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc), .grant(grant), .timeout_cnt(tcnt));
    wb_dual_master_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(0), .CNT_WIDTH(8)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(fif), .grant(f_grant), .timeout_cnt(f_tcnt));

    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    // Slave model: acks on the (ack_delay+1)-th cycle of a continuous strobe.
    bit          ack_en = 1'b1;
    int          ack_delay = 0;
    logic [31:0] rdata_val = '0;
    int          stb_cnt = 0;
    assign ifc.s_ack   = ifc.s_cyc & ifc.s_stb & ack_en & (stb_cnt == ack_delay);
    assign ifc.s_rdata = rdata_val;
    always @(posedge clk) stb_cnt <= (ifc.s_cyc && ifc.s_stb && !ifc.s_ack) ? stb_cnt + 1 : 0;

    assign fif.s_ack   = fif.s_cyc & fif.s_stb;
    assign fif.s_rdata = 32'h0;

`ifdef ARB_RESP_REG_EN
    localparam int ACK_LAT = 1;
`else
    localparam int ACK_LAT = 0;
`endif

    logic        cap_we;
    logic [3:0]  cap_sel;
    logic [31:0] cap_addr, cap_wdata;
    logic [33:0] mon_act, mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (ifc.m0_ack || ifc.m0_err || ifc.m1_ack || ifc.m1_err)) begin
            check("sb_single_master", 64'((ifc.m0_ack | ifc.m0_err) & (ifc.m1_ack | ifc.m1_err)), 64'd0);
            mon_act = {ifc.m1_ack | ifc.m1_err, ifc.m0_err | ifc.m1_err,
                       (ifc.m1_ack | ifc.m1_err) ? ifc.m1_rdata : ifc.m0_rdata};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got response %0h, expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_exp[32]) begin
                    mon_act[31:0] = '0;
                    mon_exp[31:0] = '0;
                end
                check("sb_resp", 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    task automatic drive(input bit id, input bit on, input bit we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (id) begin
            ifc.m1_cyc = on; ifc.m1_stb = on; ifc.m1_we = we;
            ifc.m1_sel = sel; ifc.m1_addr = addr; ifc.m1_wdata = wdata;
        end else begin
            ifc.m0_cyc = on; ifc.m0_stb = on; ifc.m0_we = we;
            ifc.m0_sel = sel; ifc.m0_addr = addr; ifc.m0_wdata = wdata;
        end
    endtask

    // One classic transfer; first_g is the negedge index of the first grant, gcyc the grant cycles seen.
    task automatic xfer(input bit id, input bit we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rd,
                        output int first_g, output int gcyc);
        bit done = 1'b0;
        logic [1:0] my_g = id ? 2'b10 : 2'b01;
        exp_q.push_back({id, exp_err, exp_rd});
        @(posedge clk); #1;
        drive(id, 1'b1, we, sel, addr, wdata);
        first_g = -1;
        gcyc = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (grant == my_g) begin
                gcyc++;
                if (first_g < 0) begin
                    first_g = n;
                    cap_we = ifc.s_we; cap_sel = ifc.s_sel;
                    cap_addr = ifc.s_addr; cap_wdata = ifc.s_wdata;
                end
            end
            if (id ? (ifc.m1_ack | ifc.m1_err) : (ifc.m0_ack | ifc.m0_err)) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL xfer_bound: no response for master %0d, expected one within 40 cycles", id);
        end
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_bound: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int fg, gc, acks, sa1, sa2, a1, sacnt;
        bit seen;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        fif.m0_cyc = 0; fif.m0_stb = 0; fif.m0_we = 0; fif.m0_sel = '0; fif.m0_addr = '0; fif.m0_wdata = '0;
        fif.m1_cyc = 0; fif.m1_stb = 0; fif.m1_we = 0; fif.m1_sel = '0; fif.m1_addr = '0; fif.m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_scyc", 64'(ifc.s_cyc), 64'd0);
        check("rst_tcnt", 64'(tcnt), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Single m0 read, slave acks on the third strobe cycle.
        ack_en = 1; ack_delay = 2; rdata_val = 32'hCAFEF00D;
        xfer(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'hCAFEF00D, fg, gc);
        check("rd_first_grant", 64'(fg), 64'd1);
        check("rd_grant_cycles", 64'(gc), 64'd3);
        check("rd_addr", 64'(cap_addr), 64'h100);
        check("rd_we", 64'(cap_we), 64'd0);
        @(negedge clk);
        check("rd_grant_idle", 64'(grant), 64'd0);

        // m1 write.
        ack_delay = 1; rdata_val = 32'h5A5A0000;
        xfer(1'b1, 1'b1, 4'b0011, 32'h2000, 32'h12345678, 1'b0, 32'h5A5A0000, fg, gc);
        check("wr_first_grant", 64'(fg), 64'd1);
        check("wr_we", 64'(cap_we), 64'd1);
        check("wr_sel", 64'(cap_sel), 64'h3);
        check("wr_addr", 64'(cap_addr), 64'h2000);
        check("wr_wdata", 64'(cap_wdata), 64'h12345678);

        // Watchdog: no ack, err after 4 counted grant cycles (on the 5th).
        ack_en = 0;
        xfer(1'b0, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 32'h0, fg, gc);
        check("wd_grant_cycles", 64'(gc), 64'd5);
        @(negedge clk);
        check("wd_scyc_low", 64'(ifc.s_cyc), 64'd0);
        check("wd_err_once", 64'(ifc.m0_err), 64'd0);
        check("wd_tcnt1", 64'(tcnt), 64'd1);
        repeat (254) xfer(1'b0, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 32'h0, fg, gc);
        check("wd_tcnt255", 64'(tcnt), 64'd255);
        xfer(1'b1, 1'b0, 4'hF, 32'h304, 32'h0, 1'b1, 32'h0, fg, gc);
        check("wd_tcnt_sat", 64'(tcnt), 64'd255);

        // Asynchronous reset in the middle of a grant.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_rst_grant", 64'(grant), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_scyc", 64'(ifc.s_cyc), 64'd0);
        check("arst_sstb", 64'(ifc.s_stb), 64'd0);
        check("arst_grant", 64'(grant), 64'd0);
        check("arst_ack", 64'(ifc.m0_ack | ifc.m0_err), 64'd0);
        check("arst_tcnt", 64'(tcnt), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Tie from reset, round-robin: m0, m1, m0, m1.
        ack_en = 1; ack_delay = 0; rdata_val = 32'h0000BEEF;
        exp_q.push_back({1'b0, 1'b0, 32'h0000BEEF});
        exp_q.push_back({1'b1, 1'b0, 32'h0000BEEF});
        exp_q.push_back({1'b0, 1'b0, 32'h0000BEEF});
        exp_q.push_back({1'b1, 1'b0, 32'h0000BEEF});
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        acks = 0;
        for (int n = 0; n < 40 && acks < 4; n++) begin
            @(negedge clk);
            if (ifc.m0_ack || ifc.m1_ack) acks++;
        end
        check("rr_ack_count", 64'(acks), 64'd4);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);

        // Held m0 strobe: ack latency and ack-to-next-ack turnaround.
        rdata_val = 32'h600DF00D;
        exp_q.push_back({1'b0, 1'b0, 32'h600DF00D});
        exp_q.push_back({1'b0, 1'b0, 32'h600DF00D});
        #1;
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        acks = 0; sacnt = 0; sa1 = -100; sa2 = -100; a1 = -100;
        for (int n = 0; n < 40 && acks < 2; n++) begin
            @(negedge clk);
            if (ifc.s_ack) begin
                if (sacnt == 0) sa1 = n; else sa2 = n;
                sacnt++;
            end
            if (ifc.m0_ack) begin
                if (acks == 0) a1 = n;
                acks++;
            end
        end
        check("lat_ack", 64'(a1 - sa1), 64'(ACK_LAT));
        check("lat_turnaround", 64'(sa2 - sa1), 64'(2 + ACK_LAT));
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Fixed-priority instance: m1 wins whenever it requests.
        @(posedge clk); #1;
        fif.m0_cyc = 1; fif.m0_stb = 1; fif.m1_cyc = 1; fif.m1_stb = 1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (f_grant != 2'b00) check("fp_grant_m1", 64'(f_grant), 64'd2);
        end
        @(posedge clk); #1;
        fif.m1_cyc = 0; fif.m1_stb = 0;
        seen = 1'b0;
        for (int n = 0; n < 6 && !seen; n++) begin
            @(negedge clk);
            if (f_grant == 2'b01) seen = 1'b1;
        end
        check("fp_m0_alone", 64'(seen), 64'd1);
        @(posedge clk); #1;
        fif.m0_cyc = 0; fif.m0_stb = 0;

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
